// File: rtl/bcd4_to_bin.sv
// Sequential packed-BCD to binary converter (Horner, one digit per clock, start/ready handshake).
// Define BCD2BIN_ERR_EN to flag invalid digits (0xA..0xE) on the error output.
module bcd4_to_bin #(
   parameter int DIGITS = 4,
   parameter int WIDTH  = 14
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [4*DIGITS-1:0]   bcd,
   output logic                  ready,
   output logic                  done,
   output logic [WIDTH-1:0]      value,
   output logic                  error
);

   localparam int IDXW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

   typedef enum logic {IDLE, ACCUM} state_t;

   state_t                  state_reg, state_next;
   logic [DIGITS-1:0][3:0]  shadow_reg, shadow_next;
   logic [IDXW-1:0]         idx_reg, idx_next;
   logic [WIDTH-1:0]        acc_reg, acc_next;
   logic [WIDTH-1:0]        value_reg, value_next;
   logic                    done_reg, done_next;

   logic [3:0]              digit;
   logic [3:0]              digit_val;
   logic [WIDTH+3:0]        mac;
   logic [WIDTH-1:0]        acc_step;

   // Blanks (0xF) and invalid codes both contribute zero to the result.
   assign digit     = shadow_reg[idx_reg];
   assign digit_val = (digit <= 4'd9) ? digit : 4'd0;
   assign mac       = ({4'b0, acc_reg} << 3) + ({4'b0, acc_reg} << 1)
                    + {{WIDTH{1'b0}}, digit_val};
   assign acc_step  = WIDTH'(mac);

`ifdef BCD2BIN_ERR_EN
   logic err_acc_reg, err_acc_next;
   logic error_reg, error_next;
   logic invalid;

   assign invalid = (digit >= 4'hA) && (digit <= 4'hE);
   assign error   = error_reg;
`else
   assign error = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg  <= IDLE;
         shadow_reg <= '0;
         idx_reg    <= '0;
         acc_reg    <= '0;
         value_reg  <= '0;
         done_reg   <= 1'b0;
`ifdef BCD2BIN_ERR_EN
         err_acc_reg <= 1'b0;
         error_reg   <= 1'b0;
`endif
      end else begin
         state_reg  <= state_next;
         shadow_reg <= shadow_next;
         idx_reg    <= idx_next;
         acc_reg    <= acc_next;
         value_reg  <= value_next;
         done_reg   <= done_next;
`ifdef BCD2BIN_ERR_EN
         err_acc_reg <= err_acc_next;
         error_reg   <= error_next;
`endif
      end
   end

   always_comb begin
      state_next  = state_reg;
      shadow_next = shadow_reg;
      idx_next    = idx_reg;
      acc_next    = acc_reg;
      value_next  = value_reg;
      done_next   = 1'b0;
`ifdef BCD2BIN_ERR_EN
      err_acc_next = err_acc_reg;
      error_next   = error_reg;
`endif
      case (state_reg)
         IDLE: begin
            if (start) begin
               shadow_next = bcd;
               acc_next    = '0;
               idx_next    = IDXW'(DIGITS - 1);
               state_next  = ACCUM;
`ifdef BCD2BIN_ERR_EN
               err_acc_next = 1'b0;
`endif
            end
         end
         ACCUM: begin
            acc_next = acc_step;
            idx_next = idx_reg - IDXW'(1);
`ifdef BCD2BIN_ERR_EN
            err_acc_next = err_acc_reg | invalid;
`endif
            // Least significant digit: publish result and return to idle together.
            if (idx_reg == '0) begin
               value_next = acc_step;
               done_next  = 1'b1;
               state_next = IDLE;
`ifdef BCD2BIN_ERR_EN
               error_next = err_acc_reg | invalid;
`endif
            end
         end
         default: state_next = IDLE;
      endcase
   end

   assign ready = (state_reg == IDLE);
   assign done  = done_reg;
   assign value = value_reg;

endmodule

// File: tb/tb_bcd4_to_bin.sv
// Directed self-checking bench for bcd4_to_bin (default DIGITS=4, WIDTH=14).
// Expected error values follow BCD2BIN_ERR_EN when the bench is built with it.
module tb_bcd4_to_bin;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [15:0] bcd;
   logic        ready;
   logic        done;
   logic [13:0] value;
   logic        error;

   int nvec = 0;
   int nerr = 0;

`ifdef BCD2BIN_ERR_EN
   localparam logic ERR_EXP = 1'b1;
`else
   localparam logic ERR_EXP = 1'b0;
`endif

   bcd4_to_bin dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .bcd   (bcd),
      .ready (ready),
      .done  (done),
      .value (value),
      .error (error)
   );

   always #5 clk = ~clk;

   // Runs one conversion; bcd is scrambled one cycle after the start edge.
   task automatic convert(input logic [15:0] b, output logic [13:0] v,
                          output logic e, output int lat, output int rlow);
      lat  = -1;
      rlow = 0;
      start = 1'b1;
      bcd   = b;
      @(negedge clk);
      start = 1'b0;
      bcd   = ~b;
      if (!ready) rlow++;
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk);
         if (!ready) rlow++;
         if (done) begin
            lat = k;
            break;
         end
      end
      v = value;
      e = error;
      $display("conv bcd=%h -> value=%0d error=%b latency=%0d ready_low=%0d", b, v, e, lat, rlow);
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b0; bcd = 16'h0000;
      repeat (2) @(negedge clk);
      nvec++;
      if (ready !== 1'b1 || done !== 1'b0 || value !== 14'd0 || error !== 1'b0) begin
         nerr++;
         $display("FAIL reset: ready=%b done=%b value=%0d error=%b, want 1 0 0 0", ready, done, value, error);
      end else $display("reset: ready=1 done=0 value=0 error=0");
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_basic();
      logic [13:0] v; logic e; int lat, rlow;
      convert(16'h1234, v, e, lat, rlow);
      nvec++;
      if (v !== 14'h04D2) begin nerr++; $display("FAIL basic_value: got %0d want 1234", v); end
      nvec++;
      if (lat != 4) begin nerr++; $display("FAIL basic_latency: got %0d want 4", lat); end
      nvec++;
      if (rlow != 4) begin nerr++; $display("FAIL basic_ready_low: got %0d want 4", rlow); end
      nvec++;
      if (done !== 1'b0) begin nerr++; $display("FAIL basic_done_pulse: done=%b one cycle later, want 0", done); end
   endtask

   task automatic test_values();
      logic [15:0] vin [6] = '{16'h9999, 16'h0000, 16'hFFFF, 16'hFF42, 16'h1F05, 16'h0001};
      int          vexp[6] = '{9999, 0, 0, 42, 1005, 1};
      logic [13:0] v; logic e; int lat, rlow;
      for (int i = 0; i < 6; i++) begin
         convert(vin[i], v, e, lat, rlow);
         nvec++;
         if (v !== 14'(vexp[i]) || e !== 1'b0 || lat != 4) begin
            nerr++;
            $display("FAIL values[%0d]: bcd=%h got value=%0d error=%b lat=%0d want %0d 0 4",
                     i, vin[i], v, e, lat, vexp[i]);
         end
      end
   endtask

   task automatic test_error();
      logic [13:0] v; logic e; int lat, rlow;
      convert(16'h12A4, v, e, lat, rlow);
      nvec++;
      if (v !== 14'd1204 || e !== ERR_EXP) begin
         nerr++;
         $display("FAIL error_set: got value=%0d error=%b want 1204 %b", v, e, ERR_EXP);
      end
      repeat (3) @(negedge clk);
      nvec++;
      if (error !== ERR_EXP || value !== 14'd1204) begin
         nerr++;
         $display("FAIL error_hold: got value=%0d error=%b want 1204 %b", value, error, ERR_EXP);
      end
      convert(16'h0001, v, e, lat, rlow);
      nvec++;
      if (v !== 14'd1 || e !== 1'b0) begin
         nerr++;
         $display("FAIL error_clear: got value=%0d error=%b want 1 0", v, e);
      end
   endtask

   task automatic test_ignore_start();
      int ndone = 0;
      start = 1'b1; bcd = 16'h0321;
      @(negedge clk);
      start = 1'b0; bcd = 16'h0777;
      @(negedge clk);
      start = 1'b1; bcd = 16'h0555;
      @(negedge clk);
      start = 1'b0;
      for (int k = 0; k < 12; k++) begin
         if (done) ndone++;
         @(negedge clk);
      end
      $display("ignore_start: dones=%0d value=%0d", ndone, value);
      nvec++;
      if (ndone != 1) begin nerr++; $display("FAIL ignore_done_count: got %0d want 1", ndone); end
      nvec++;
      if (value !== 14'd321) begin nerr++; $display("FAIL ignore_value: got %0d want 321", value); end
   endtask

   task automatic test_reset_mid();
      int ndone = 0;
      start = 1'b1; bcd = 16'h5678;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      $display("reset_mid: ready=%b value=%0d done=%b", ready, value, done);
      nvec++;
      if (ready !== 1'b1 || value !== 14'd0 || done !== 1'b0) begin
         nerr++;
         $display("FAIL reset_mid: ready=%b value=%0d done=%b want 1 0 0", ready, value, done);
      end
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         if (done) ndone++;
      end
      nvec++;
      if (ndone != 0 || value !== 14'd0) begin
         nerr++;
         $display("FAIL reset_mid_discard: dones=%0d value=%0d want 0 0", ndone, value);
      end
   endtask

   task automatic test_back_to_back();
      int cyc[$];
      start = 1'b1; bcd = 16'h0042;
      for (int k = 0; k < 22; k++) begin
         @(negedge clk);
         if (done) begin
            cyc.push_back(k);
            nvec++;
            if (value !== 14'd42) begin nerr++; $display("FAIL b2b_value: got %0d want 42", value); end
         end
      end
      start = 1'b0;
      $display("back_to_back: %0d done pulses", cyc.size());
      nvec++;
      if (cyc.size() != 4) begin
         nerr++;
         $display("FAIL b2b_count: got %0d want 4", cyc.size());
      end else begin
         nvec++;
         if (cyc[0] != 4 || cyc[1] - cyc[0] != 5 || cyc[2] - cyc[1] != 5 || cyc[3] - cyc[2] != 5) begin
            nerr++;
            $display("FAIL b2b_spacing: at %0d %0d %0d %0d want 4 9 14 19", cyc[0], cyc[1], cyc[2], cyc[3]);
         end
      end
      repeat (6) @(negedge clk);
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; bcd = 16'h0000;
      @(negedge clk);
      test_reset();
      test_basic();
      test_values();
      test_error();
      test_ignore_start();
      test_reset_mid();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
